fetch_pc_unit: RTL and testbench

- Instruction-fetch / PC-generation stage directly upstream of the 32-bit PC adder.
- Holds the architectural fetch PC and drives the adder operands (PC, +2/+4); consumes the adder sum as the next sequential PC.
- Issues word fetches to instruction memory and realigns 16/32-bit RV32IMAC instructions, including ones that straddle a word boundary.
- Presents instructions to decode over a valid/ready handshake.

---
 rtl/fetch_pc_unit.sv | 213 +++++++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction fetch / PC generation stage feeding the 32-bit PC adder.
// Fetches aligned words, realigns 16/32-bit instructions and hands them to decode.
// Optional compressed (RVC) support, including word-straddling instructions, is
// enabled by defining FETCH_RVC_EN; without it every instruction is one aligned word.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] adder_a,
    output logic [31:0] adder_b,
    input  logic [31:0] adder_c,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_is_compressed
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned WAW  = XLEN - 2;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ASM  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

`ifdef FETCH_RVC_EN
    localparam logic [XLEN-1:0] PC_MASK = 32'hFFFF_FFFE;
`else
    localparam logic [XLEN-1:0] PC_MASK = 32'hFFFF_FFFC;
`endif
    localparam logic [XLEN-1:0] RESET_PC_AL = RESET_PC & PC_MASK;

    logic [1:0]      state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            imem_req_nxt;
    logic [XLEN-1:0] imem_addr_nxt;
    logic            if_valid_nxt;
    logic [XLEN-1:0] if_instr_nxt;
    logic [XLEN-1:0] if_pc_nxt;
    logic            if_is_compressed_nxt;
    logic [XLEN-1:0] wbuf, wbuf_nxt;
    logic [WAW-1:0]  waddr, waddr_nxt;
    logic            wvalid, wvalid_nxt;
    logic            discard, discard_nxt;
    logic            fetch_next_word;
    logic            fire;
    logic            asm_done;
    logic [XLEN-1:0] asm_instr;
    logic            asm_comp;
`ifdef FETCH_RVC_EN
    logic [15:0]     hbuf, hbuf_nxt;
    logic            hvalid, hvalid_nxt;
`endif

    assign fire    = if_valid & if_ready;
    assign adder_a = if_pc;
`ifdef FETCH_RVC_EN
    assign adder_b         = if_is_compressed ? 32'd2 : 32'd4;
    assign fetch_next_word = hvalid;
`else
    assign adder_b         = 32'd4;
    assign fetch_next_word = 1'b0;
`endif

    // Instruction realignment from the word buffer (and pending low half, if any)
    always_comb begin
        asm_done  = 1'b1;
        asm_instr = wbuf;
        asm_comp  = 1'b0;
`ifdef FETCH_RVC_EN
        if (hvalid) begin
            asm_instr = {wbuf[15:0], hbuf};
        end else if (!pc[1]) begin
            if (wbuf[1:0] != 2'b11) begin
                asm_instr = {16'h0000, wbuf[15:0]};
                asm_comp  = 1'b1;
            end
        end else if (wbuf[17:16] != 2'b11) begin
            asm_instr = {16'h0000, wbuf[31:16]};
            asm_comp  = 1'b1;
        end else begin
            asm_done = 1'b0;
        end
`endif
    end

    // Next-state and next-output logic; redirect overrides every state
    always_comb begin
        state_nxt            = state;
        pc_nxt               = pc;
        imem_req_nxt         = 1'b0;
        imem_addr_nxt        = imem_addr;
        if_valid_nxt         = if_valid;
        if_instr_nxt         = if_instr;
        if_pc_nxt            = if_pc;
        if_is_compressed_nxt = if_is_compressed;
        wbuf_nxt             = wbuf;
        waddr_nxt            = waddr;
        wvalid_nxt           = wvalid;
        discard_nxt          = discard;
`ifdef FETCH_RVC_EN
        hbuf_nxt             = hbuf;
        hvalid_nxt           = hvalid;
`endif
        if (redirect_valid) begin
            pc_nxt       = redirect_pc & PC_MASK;
            if_valid_nxt = 1'b0;
            wvalid_nxt   = 1'b0;
            state_nxt    = ST_REQ;
            // A response still in flight must be dropped; one arriving now is simply ignored
            discard_nxt  = ((state == ST_WAIT) || discard) && !imem_rvalid;
`ifdef FETCH_RVC_EN
            hvalid_nxt   = 1'b0;
`endif
        end else begin
            case (state)
                ST_REQ: begin
                    if (discard) begin
                        if (imem_rvalid) discard_nxt = 1'b0;
                    end else begin
                        imem_req_nxt  = 1'b1;
                        imem_addr_nxt = fetch_next_word ? {pc[31:2] + WAW'(1), 2'b00}
                                                        : {pc[31:2], 2'b00};
                        state_nxt     = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        wbuf_nxt   = imem_rdata;
                        waddr_nxt  = imem_addr[31:2];
                        wvalid_nxt = 1'b1;
                        state_nxt  = ST_ASM;
                    end
                end
                ST_ASM: begin
                    if (asm_done) begin
                        if_valid_nxt         = 1'b1;
                        if_instr_nxt         = asm_instr;
                        if_pc_nxt            = pc;
                        if_is_compressed_nxt = asm_comp;
                        state_nxt            = ST_HOLD;
                    end else begin
`ifdef FETCH_RVC_EN
                        hbuf_nxt   = wbuf[31:16];
                        hvalid_nxt = 1'b1;
`endif
                        state_nxt  = ST_REQ;
                    end
                end
                default: begin
                    if (fire) begin
                        pc_nxt       = adder_c & PC_MASK;
                        if_valid_nxt = 1'b0;
`ifdef FETCH_RVC_EN
                        hvalid_nxt   = 1'b0;
`endif
                        // Follow-on instruction in the buffered word needs no refetch
                        if (wvalid && (adder_c[31:2] == waddr)) state_nxt = ST_ASM;
                        else                                    state_nxt = ST_REQ;
                    end
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_REQ;
            pc               <= RESET_PC_AL;
            imem_req         <= 1'b0;
            imem_addr        <= {RESET_PC[31:2], 2'b00};
            if_valid         <= 1'b0;
            if_instr         <= '0;
            if_pc            <= RESET_PC_AL;
            if_is_compressed <= 1'b0;
            wbuf             <= '0;
            waddr            <= '0;
            wvalid           <= 1'b0;
            discard          <= 1'b0;
`ifdef FETCH_RVC_EN
            hbuf             <= '0;
            hvalid           <= 1'b0;
`endif
        end else begin
            state            <= state_nxt;
            pc               <= pc_nxt;
            imem_req         <= imem_req_nxt;
            imem_addr        <= imem_addr_nxt;
            if_valid         <= if_valid_nxt;
            if_instr         <= if_instr_nxt;
            if_pc            <= if_pc_nxt;
            if_is_compressed <= if_is_compressed_nxt;
            wbuf             <= wbuf_nxt;
            waddr            <= waddr_nxt;
            wvalid           <= wvalid_nxt;
            discard          <= discard_nxt;
`ifdef FETCH_RVC_EN
            hbuf             <= hbuf_nxt;
            hvalid           <= hvalid_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: memory responder, external adder and an
// instruction-stream reference model that walks memory halfword by halfword.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef FETCH_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] adder_a, adder_b, adder_c;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr, if_pc;
    logic        if_is_compressed;

    int unsigned checks = 0;
    int unsigned fails = 0;
    int unsigned req_count = 0;
    logic [31:0] last_req_addr = '0;
    int unsigned resp_lat = 0;
    bit          ready_rand = 1'b0;
    logic [31:0] mem [int unsigned];

    fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .adder_a(adder_a), .adder_b(adder_b), .adder_c(adder_c),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_is_compressed(if_is_compressed)
    );

    always #5 clk = ~clk;
    assign adder_c = adder_a + adder_b;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        int unsigned k;
        k = {2'b00, a[31:2]};
        if (mem.exists(k)) return mem[k];
        return 32'h0000_0013;
    endfunction

    function automatic logic [15:0] rd_half(input logic [31:0] a);
        logic [31:0] w;
        w = rd_word(a);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem[{2'b00, a[31:2]}] = d;
    endtask

    function automatic logic [31:0] norm(input logic [31:0] a);
        return RVC ? (a & 32'hFFFF_FFFE) : (a & 32'hFFFF_FFFC);
    endfunction

    // Reference: the instruction starting at pc and the pc of the one after it
    function automatic void model_at(input logic [31:0] pc, output logic [31:0] instr,
                                     output bit comp, output logic [31:0] npc);
        logic [15:0] lo, hi;
        if (!RVC) begin
            instr = rd_word(pc);
            comp  = 1'b0;
            npc   = pc + 32'd4;
            return;
        end
        lo = rd_half(pc);
        if (lo[1:0] != 2'b11) begin
            instr = {16'h0000, lo};
            comp  = 1'b1;
            npc   = pc + 32'd2;
        end else begin
            hi    = rd_half(pc + 32'd2);
            instr = {hi, lo};
            comp  = 1'b0;
            npc   = pc + 32'd4;
        end
    endfunction

    // Instruction memory: one response per request after 1..N cycles
    initial begin
        logic [31:0] a;
        int unsigned lat;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (!rst && imem_req) begin
                req_count++;
                last_req_addr = imem_addr;
                a   = imem_addr;
                lat = (resp_lat == 0) ? $urandom_range(1, 3) : resp_lat;
                repeat (lat) begin
                    @(negedge clk);
                    if (rst) break;
                end
                if (!rst) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = rd_word(a);
                end
            end
        end
    end

    task automatic do_redirect(input logic [31:0] tgt, output int unsigned base);
        @(negedge clk);
        if_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        @(negedge clk);
        redirect_valid = 1'b0;
        base           = req_count;
    endtask

    // Waits for a handshake; returns what decode would see on that fire
    task automatic get_instr(output bit ok, output logic [31:0] pc, output logic [31:0] instr,
                             output bit comp, output logic [31:0] a, output logic [31:0] b);
        ok = 1'b0; pc = '0; instr = '0; comp = 1'b0; a = '0; b = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (if_valid && if_ready) begin
                ok = 1'b1; pc = if_pc; instr = if_instr; comp = if_is_compressed;
                a = adder_a; b = adder_b;
                break;
            end
        end
    endtask

    task automatic wait_req(input int unsigned base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_count != base) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; if_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC || if_valid !== 1'b0 || if_instr !== 32'h0 ||
            if_pc !== RST_PC || if_is_compressed !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got req=%b addr=%h v=%b instr=%h pc=%h c=%b, need 0 %h 0 0 %h 0",
                     imem_req, imem_addr, if_valid, if_instr, if_pc, if_is_compressed, RST_PC, RST_PC);
        end
        checks++;
        if (adder_a !== RST_PC || adder_b !== 32'd4) begin
            fails++; $display("FAIL reset_adder: got a=%h b=%h, need %h 4", adder_a, adder_b, RST_PC);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            fails++; $display("FAIL first_req: got req=%b addr=%h, need 1 %h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        bit ok; logic [31:0] p, ins, a, b; bit c; int unsigned base;
        get_instr(ok, p, ins, c, a, b);
        base = req_count;
        checks++;
        if (!ok || p !== RST_PC || ins !== 32'h13 || c !== 1'b0 || a !== RST_PC || b !== 32'd4) begin
            fails++; $display("FAIL seq_first: got ok=%b pc=%h instr=%h c=%b a=%h b=%h, need pc=%h instr=13 c=0 b=4",
                              ok, p, ins, c, a, b, RST_PC);
        end
        wait_req(base, ok);
        checks++;
        if (!ok || last_req_addr !== RST_PC + 32'd4) begin
            fails++; $display("FAIL seq_next_addr: got ok=%b addr=%h, need %h", ok, last_req_addr, RST_PC + 32'd4);
        end
    endtask

    task automatic test_compressed();
        bit ok; logic [31:0] p, ins, a, b; bit c; int unsigned base;
        do_redirect(32'h200, base);
        get_instr(ok, p, ins, c, a, b);
        checks++;
        if (!ok || p !== 32'h200 || ins !== (RVC ? 32'h4501 : 32'h45014501) || c !== RVC ||
            b !== (RVC ? 32'd2 : 32'd4)) begin
            fails++; $display("FAIL rvc_first: got ok=%b pc=%h instr=%h c=%b b=%h", ok, p, ins, c, b);
        end
        get_instr(ok, p, ins, c, a, b);
        checks++;
        if (!ok || p !== (RVC ? 32'h202 : 32'h204) || ins !== (RVC ? 32'h4501 : 32'h13) || c !== RVC) begin
            fails++; $display("FAIL rvc_second: got ok=%b pc=%h instr=%h c=%b", ok, p, ins, c);
        end
        checks++;
        if (req_count - base != (RVC ? 1 : 2)) begin
            fails++; $display("FAIL rvc_req_count: got %0d, need %0d", req_count - base, RVC ? 1 : 2);
        end
    endtask

    task automatic test_straddle();
        bit ok; logic [31:0] p, ins, a, b; bit c; int unsigned base;
        do_redirect(32'h302, base);
        get_instr(ok, p, ins, c, a, b);
        checks++;
        if (!ok || p !== (RVC ? 32'h302 : 32'h300) || ins !== (RVC ? 32'h13 : 32'h00130001) ||
            c !== 1'b0 || b !== 32'd4 || req_count - base != (RVC ? 2 : 1)) begin
            fails++; $display("FAIL straddle_first: got ok=%b pc=%h instr=%h c=%b b=%h reqs=%0d",
                              ok, p, ins, c, b, req_count - base);
        end
        get_instr(ok, p, ins, c, a, b);
        checks++;
        if (!ok || p !== (RVC ? 32'h306 : 32'h304) || ins !== (RVC ? 32'hABCD : 32'hABCD0000) ||
            c !== RVC || req_count - base != 2) begin
            fails++; $display("FAIL straddle_second: got ok=%b pc=%h instr=%h c=%b reqs=%0d",
                              ok, p, ins, c, req_count - base);
        end
    endtask

    task automatic test_backpressure();
        bit ok; int unsigned base, cnt0;
        do_redirect(32'h500, base);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if_valid) begin ok = 1'b1; break; end
        end
        cnt0 = req_count;
        checks++;
        if (!ok) begin fails++; $display("FAIL bp_valid_timeout: got no if_valid, need if_valid=1"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (if_valid !== 1'b1 || if_instr !== 32'h00A00093 || if_pc !== 32'h500) begin
                fails++; $display("FAIL bp_hold: got v=%b instr=%h pc=%h, need 1 00a00093 00000500",
                                  if_valid, if_instr, if_pc);
            end
        end
        checks++;
        if (req_count != cnt0) begin
            fails++; $display("FAIL bp_no_req: got %0d reqs, need %0d", req_count, cnt0);
        end
        @(negedge clk); if_ready = 1'b1;
        @(negedge clk); if_ready = 1'b0;
        wait_req(cnt0, ok);
        checks++;
        if (!ok || last_req_addr !== 32'h504) begin
            fails++; $display("FAIL bp_next_addr: got ok=%b addr=%h, need 00000504", ok, last_req_addr);
        end
    endtask

    task automatic test_redirect_wait();
        bit ok; logic [31:0] p, ins, a, b; bit c; int unsigned base, base2;
        resp_lat = 6;
        do_redirect(32'h400, base);
        wait_req(base, ok);
        checks++;
        if (!ok || last_req_addr !== 32'h400) begin
            fails++; $display("FAIL rw_req400: got ok=%b addr=%h, need 00000400", ok, last_req_addr);
        end
        do_redirect(32'h801, base2);
        resp_lat = 0;
        wait_req(base2, ok);
        checks++;
        if (!ok || last_req_addr !== 32'h800) begin
            fails++; $display("FAIL rw_req800: got ok=%b addr=%h, need 00000800", ok, last_req_addr);
        end
        get_instr(ok, p, ins, c, a, b);
        checks++;
        if (!ok || p !== 32'h800 || ins !== 32'h00200093) begin
            fails++; $display("FAIL rw_first_instr: got ok=%b pc=%h instr=%h, need 00000800 00200093", ok, p, ins);
        end
    endtask

    task automatic test_random_stream();
        bit ok; logic [31:0] p, ins, a, b; bit c; int unsigned base;
        logic [31:0] mpc, ei, en, tgt; bit ec; logic [15:0] h0, h1;
        for (int w = 0; w < 64; w++) begin
            h0 = 16'($urandom); if ($urandom_range(0, 1) == 1) h0[1:0] = 2'b11;
            h1 = 16'($urandom); if ($urandom_range(0, 1) == 1) h1[1:0] = 2'b11;
            wr(32'h1000 + 32'(w * 4), {h1, h0});
        end
        tgt = 32'h1000 + 32'($urandom_range(0, 15) * 2) + 32'($urandom_range(0, 1));
        do_redirect(tgt, base);
        mpc = norm(tgt);
        ready_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 20) begin
                tgt = 32'h1000 + 32'($urandom_range(0, 40) * 2);
                do_redirect(tgt, base);
                mpc = norm(tgt);
            end
            get_instr(ok, p, ins, c, a, b);
            model_at(mpc, ei, ec, en);
            checks++;
            if (!ok || p !== mpc || ins !== ei || c !== ec || a !== mpc || b !== (ec ? 32'd2 : 32'd4)) begin
                fails++; $display("FAIL stream[%0d]: got ok=%b pc=%h instr=%h c=%b b=%h, need pc=%h instr=%h c=%b",
                                  i, ok, p, ins, c, b, mpc, ei, ec);
            end
            mpc = en;
        end
        ready_rand = 1'b0;
    endtask

    task automatic test_async_reset();
        bit ok; logic [31:0] p, ins, a, b; bit c; int unsigned base;
        do_redirect(32'h500, base);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if_valid) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin fails++; $display("FAIL ar_valid_timeout: got no if_valid, need if_valid=1"); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== RST_PC || imem_req !== 1'b0 ||
            imem_addr !== RST_PC || if_is_compressed !== 1'b0 || adder_a !== RST_PC) begin
            fails++; $display("FAIL ar_immediate: got v=%b instr=%h pc=%h req=%b addr=%h c=%b a=%h",
                              if_valid, if_instr, if_pc, imem_req, imem_addr, if_is_compressed, adder_a);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            fails++; $display("FAIL ar_restart_req: got req=%b addr=%h, need 1 %h", imem_req, imem_addr, RST_PC);
        end
        get_instr(ok, p, ins, c, a, b);
        checks++;
        if (!ok || p !== RST_PC || ins !== 32'h13) begin
            fails++; $display("FAIL ar_restart_instr: got ok=%b pc=%h instr=%h, need %h 00000013", ok, p, ins, RST_PC);
        end
    endtask

    initial begin
        wr(32'h100, 32'h0000_0013);
        wr(32'h104, 32'h0000_0013);
        wr(32'h200, 32'h4501_4501);
        wr(32'h204, 32'h0000_0013);
        wr(32'h300, 32'h0013_0001);
        wr(32'h304, 32'hABCD_0000);
        wr(32'h400, 32'h1111_1111);
        wr(32'h500, 32'h00A0_0093);
        wr(32'h504, 32'h0000_0013);
        wr(32'h800, 32'h0020_0093);
        test_reset();
        test_sequential();
        test_compressed();
        test_straddle();
        test_backpressure();
        test_redirect_wait();
        test_random_stream();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, need finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
